redirect_ctrl: RTL and testbench

Pipeline redirect and interrupt-entry controller for the 5-stage OTTER core.
- Arbitrates the EX-stage control-flow decision (raw pcSource from the branch condition generator), `mret` and external interrupts into one PC mux select and one flush strobe.
- Sequences interrupt entry through a small FSM so a trap is only taken at a safe point.
- Sits between the EX stage, the CSR unit and the IF-stage PC mux.

---
 rtl/otter_ctrl_pkg.sv | 21 ++
 rtl/intr_sync.sv | 27 ++
 rtl/redirect_ctrl.sv | 115 +++++++++++
 tb/tb_redirect_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_ctrl_pkg.sv
// Shared encodings for the OTTER redirect/interrupt control path:
// the PC mux select values and the interrupt-entry FSM states.
package otter_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_TRAP   = 3'd4,
        PC_MRET   = 3'd5
    } pc_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TAKE,
        IN_ISR
    } intr_state_t;

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchronizer for the external interrupt line. It is only
// built and used when OTTER_INTR_SYNC_EN is defined.
`ifdef OTTER_INTR_SYNC_EN
module intr_sync (
    input  logic CLK,
    input  logic RST,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`endif

// File: rtl/redirect_ctrl.sv
// Redirect/interrupt-entry controller: merges EX control flow, mret and
// interrupts into one PC select and flush. Option: OTTER_INTR_SYNC_EN.
module redirect_ctrl
    import otter_ctrl_pkg::*;
#(
    parameter int PC_SEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                INTR,
    input  logic                MIE,
    input  logic                EX_VALID,
    input  logic [PC_SEL_W-1:0] EX_PCSRC,
    input  logic                EX_MRET,
    input  logic                STALL,
    output logic [PC_SEL_W-1:0] PC_SEL,
    output logic                FLUSH,
    output logic                INT_TAKEN,
    output logic                INT_ACTIVE,
    output logic [CNT_W-1:0]    REDIRECT_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    intr_state_t         r_state;
    intr_state_t         w_state_next;
    logic                r_pend;
    logic                r_int_active;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_intr;
    logic [PC_SEL_W-1:0] w_ex_src;
    logic                w_mret_go;
    logic                w_safe;
    logic                w_take_go;
    logic [PC_SEL_W-1:0] w_sel;

`ifdef OTTER_INTR_SYNC_EN
    intr_sync u_intr_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (INTR),
        .o_sync  (w_intr)
    );
`else
    assign w_intr = INTR;
`endif

    // Encodings above the mepc select are not real pcSource values; drop them.
    assign w_ex_src  = (EX_PCSRC > PC_SEL_W'(PC_MRET)) ? PC_SEL_W'(PC_SEQ) : EX_PCSRC;
    assign w_mret_go = EX_VALID & EX_MRET & ~STALL;
    assign w_safe    = ~STALL & ~(EX_VALID & ((w_ex_src != PC_SEL_W'(PC_SEQ)) | EX_MRET));
    assign w_take_go = (r_state == TAKE) & ~STALL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_pend       <= 1'b0;
            r_int_active <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_int_active <= (w_state_next == IN_ISR);
            if (w_intr) begin
                r_pend <= 1'b1;
            end else if (w_take_go) begin
                r_pend <= 1'b0;
            end
            if ((w_sel != PC_SEL_W'(PC_SEQ)) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_pend & MIE) w_state_next = ARMED;
            end
            ARMED: begin
                if (!MIE)        w_state_next = IDLE;
                else if (w_safe) w_state_next = TAKE;
            end
            TAKE: begin
                if (!STALL) w_state_next = IN_ISR;
            end
            IN_ISR: begin
                if (w_mret_go) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The trap owns the PC mux in TAKE; the EX instruction becomes the mepc target.
    always_comb begin
        w_sel = PC_SEL_W'(PC_SEQ);
        if (RST) begin
            w_sel = PC_SEL_W'(PC_SEQ);
        end else if (r_state == TAKE) begin
            if (!STALL) w_sel = PC_SEL_W'(PC_TRAP);
        end else if (w_mret_go) begin
            w_sel = PC_SEL_W'(PC_MRET);
        end else if (EX_VALID & ~STALL) begin
            w_sel = w_ex_src;
        end
    end

    assign PC_SEL       = w_sel;
    assign FLUSH        = (w_sel != PC_SEL_W'(PC_SEQ));
    assign INT_TAKEN    = w_take_go & ~RST;
    assign INT_ACTIVE   = r_int_active;
    assign REDIRECT_CNT = r_cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Randomized and directed bench for redirect_ctrl against a cycle-level
// behavioural model of the redirect and interrupt-entry rules.
module tb_redirect_ctrl;

    localparam int PW   = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef OTTER_INTR_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int BASE_LAT = 3 + 2 * SYNC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          intr = 1'b0;
    logic          mie = 1'b0;
    logic          ex_valid = 1'b0;
    logic [PW-1:0] ex_pcsrc = '0;
    logic          ex_mret = 1'b0;
    logic          stall = 1'b0;
    logic [PW-1:0] pc_sel;
    logic          flush;
    logic          int_taken;
    logic          int_active;
    logic [CW-1:0] redirect_cnt;

    redirect_ctrl #(.PC_SEL_W(PW), .CNT_W(CW)) dut (
        .CLK          (clk),
        .RST          (rst),
        .INTR         (intr),
        .MIE          (mie),
        .EX_VALID     (ex_valid),
        .EX_PCSRC     (ex_pcsrc),
        .EX_MRET      (ex_mret),
        .STALL        (stall),
        .PC_SEL       (pc_sel),
        .FLUSH        (flush),
        .INT_TAKEN    (int_taken),
        .INT_ACTIVE   (int_active),
        .REDIRECT_CNT (redirect_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 = waiting, 1 = armed, 2 = taking trap, 3 = in handler.
    int m_phase = 0;
    bit m_pend  = 0;
    bit m_act   = 0;
    int m_cnt   = 0;
    bit m_s1    = 0;
    bit m_s2    = 0;
    bit last_taken = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int  eff, sel, nph;
        bit  taken, safe, intr_in;
        @(negedge clk);
        eff = (int'(ex_pcsrc) >= 6) ? 0 : int'(ex_pcsrc);
        if (rst)                              sel = 0;
        else if (m_phase == 2)                sel = stall ? 0 : 4;
        else if (stall)                       sel = 0;
        else if (ex_valid && ex_mret)         sel = 5;
        else if (ex_valid)                    sel = eff;
        else                                  sel = 0;
        taken = !rst && (m_phase == 2) && !stall;
        chk("pc_sel", 32'(pc_sel), 32'(sel));
        chk("flush", 32'(flush), 32'(sel != 0));
        chk("int_taken", 32'(int_taken), 32'(taken));
        chk("int_active", 32'(int_active), 32'(m_act));
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
        last_taken = int_taken;
        if (rst) begin
            m_phase = 0; m_pend = 0; m_act = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            safe    = !stall && !(ex_valid && (eff != 0 || ex_mret));
            intr_in = SYNC ? m_s2 : intr;
            nph = m_phase;
            if (m_phase == 0 && m_pend && mie) nph = 1;
            else if (m_phase == 1 && !mie)     nph = 0;
            else if (m_phase == 1 && safe)     nph = 2;
            else if (m_phase == 2 && !stall)   nph = 3;
            else if (m_phase == 3 && ex_valid && ex_mret && !stall) nph = 0;
            if (intr_in)     m_pend = 1;
            else if (taken)  m_pend = 0;
            if (sel != 0 && m_cnt < CMAX) m_cnt++;
            m_act   = (nph == 3);
            m_s2    = m_s1;
            m_s1    = intr;
            m_phase = nph;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 0; ex_pcsrc = '0; ex_mret = 0; stall = 0;
    endtask

    task automatic do_reset();
        rst = 1; intr = 0; ex_idle();
        step();
        step();
        rst = 0;
    endtask

    // Pulse INTR once, optionally present a JAL in the armed cycle, and measure trap latency.
    task automatic lat_test(input string tag, input bit unsafe, input int expect_lat);
        int cyc;
        bit found;
        do_reset();
        mie = 1; intr = 1;
        step();
        intr = 0;
        cyc = -1; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            ex_idle();
            if (unsafe && k == BASE_LAT - 1) begin
                ex_valid = 1; ex_pcsrc = PW'(3);
            end
            step();
            if (last_taken) begin
                found = 1; cyc = k;
            end
        end
        ex_idle();
        chk(tag, 32'(cyc), 32'(expect_lat));
        step();
        chk({tag, "_active"}, 32'(int_active), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (2) @(posedge clk);
        #1;
        m_phase = 0; m_pend = 0; m_act = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
        step();
        chk("reset_active", 32'(int_active), 32'd0);
        chk("reset_cnt", 32'(redirect_cnt), 32'd0);
        rst = 0;

        // Branch redirect, same-cycle select, then count increment.
        ex_valid = 1; ex_pcsrc = PW'(2);
        step();
        ex_idle();
        step();
        chk("branch_cnt", 32'(redirect_cnt), 32'd1);

        // Stall hides a JAL for two cycles.
        ex_valid = 1; ex_pcsrc = PW'(3); stall = 1;
        step(); step();
        stall = 0;
        step();
        ex_idle();

        // Out-of-range raw selects act as sequential.
        ex_valid = 1; ex_pcsrc = PW'(6); step();
        ex_pcsrc = PW'(7); step();
        ex_idle();

        // mret outside a handler still redirects to mepc.
        ex_valid = 1; ex_mret = 1; step();
        ex_idle();
        step();
        chk("cnt_saturated", 32'(redirect_cnt), 32'(CMAX));

        lat_test("int_latency", 1'b0, BASE_LAT);

        // Nested request while in the handler must not trap.
        intr = 1; step(); intr = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("nested_no_take", 32'(last_taken), 32'd0);
        end
        ex_valid = 1; ex_mret = 1; step();
        ex_idle();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (last_taken) found = 1;
        end
        chk("retake_seen", 32'(found), 32'd1);

        lat_test("unsafe_latency", 1'b1, BASE_LAT + 1);

        // Reset while the trap is held by a stall.
        do_reset();
        mie = 1; intr = 1; step(); intr = 0;
        for (int k = 0; k < 20 && m_phase != 2; k++) step();
        stall = 1; step();
        rst = 1; step();
        rst = 0; stall = 0; step();
        chk("rst_take_active", 32'(int_active), 32'd0);
        for (int k = 0; k < 6; k++) step();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            intr     = ($urandom_range(0, 7) == 0);
            mie      = ($urandom_range(0, 9) != 0);
            ex_valid = $urandom_range(0, 1);
            ex_pcsrc = ($urandom_range(0, 2) == 0) ? PW'($urandom_range(1, 3)) : PW'(0);
            ex_mret  = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
